// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter that shares one pipelined sprite ROM among the sprite generators.
// Each return word is tagged with the id of the requester that owns it.
module sprite_rom_arbiter #(
  parameter int N_REQ   = 7,
  parameter int AW      = 17,
  parameter int DW      = 8,
  parameter int ROM_LAT = 2,
  parameter int IDW     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_i,
  input  logic [N_REQ*AW-1:0]   req_addr_i,
  output logic [N_REQ-1:0]      gnt_o,
  output logic                  rom_rd_o,
  output logic [AW-1:0]         rom_addr_o,
  input  logic [DW-1:0]         rom_q_i,
  output logic                  rvalid_o,
  output logic [IDW-1:0]        rid_o,
  output logic [DW-1:0]         rdata_o,
  output logic                  busy_o
);

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             rom_rd_q, rom_rd_d;
  logic [AW-1:0]    rom_addr_q, rom_addr_d;
  logic [IDW-1:0]   id_q, id_d;

  logic [ROM_LAT-1:0] tag_vld_q;
  logic [IDW-1:0]     tag_id_q [ROM_LAT];

  logic             rvalid_q;
  logic [IDW-1:0]   rid_q;
  logic [DW-1:0]    rdata_q;

  logic [N_REQ-1:0] req_m;
  logic             found;
  logic [IDW-1:0]   win;
  int               ptr_int;

  // Two passes: first the requesters at or above ptr, then wrap to the lowest index.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    req_m      = req_i & ~gnt_q;
    ptr_int    = int'(ptr_q);
    found      = 1'b0;
    win        = '0;
    gnt_d      = '0;
    rom_addr_d = rom_addr_q;
    id_d       = id_q;
    if (ptr_int >= N_REQ) ptr_int = 0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_m[i] && (i >= ptr_int)) begin
        found      = 1'b1;
        win        = IDW'(i);
        gnt_d      = '0;
        gnt_d[i]   = 1'b1;
        rom_addr_d = req_addr_i[i*AW +: AW];
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_m[i]) begin
        found      = 1'b1;
        win        = IDW'(i);
        gnt_d      = '0;
        gnt_d[i]   = 1'b1;
        rom_addr_d = req_addr_i[i*AW +: AW];
      end
    end
    rom_rd_d = found;
    ptr_d    = ptr_q;
    if (found) begin
      id_d  = win;
      ptr_d = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      gnt_q      <= '0;
      rom_rd_q   <= 1'b0;
      rom_addr_q <= '0;
      id_q       <= '0;
      tag_vld_q  <= '0;
      rvalid_q   <= 1'b0;
      rid_q      <= '0;
      rdata_q    <= '0;
    end else begin
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      rom_rd_q   <= rom_rd_d;
      rom_addr_q <= rom_addr_d;
      id_q       <= id_d;
      tag_vld_q[0] <= rom_rd_q;
      for (int i = 1; i < ROM_LAT; i++) tag_vld_q[i] <= tag_vld_q[i-1];
      rvalid_q <= tag_vld_q[ROM_LAT-1];
      if (tag_vld_q[ROM_LAT-1]) begin
        rid_q   <= tag_id_q[ROM_LAT-1];
        rdata_q <= rom_q_i;
      end
    end
  end

  // NOTE: the id payload needs no reset; its valid bit alone decides whether it is used.
  always_ff @(posedge clk) begin
    tag_id_q[0] <= id_q;
    for (int i = 1; i < ROM_LAT; i++) tag_id_q[i] <= tag_id_q[i-1];
  end

  assign gnt_o      = gnt_q;
  assign rom_rd_o   = rom_rd_q;
  assign rom_addr_o = rom_addr_q;
  assign rvalid_o   = rvalid_q;
  assign rid_o      = rid_q;
  assign rdata_o    = rdata_q;
  assign busy_o     = (|tag_vld_q) | rvalid_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a latency-matched ROM model and a return scoreboard.
module tb_sprite_rom_arbiter;
  localparam int N_REQ   = 7;
  localparam int AW      = 17;
  localparam int DW      = 8;
  localparam int ROM_LAT = 2;
  localparam int IDW     = 3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N_REQ-1:0]    req = '0;
  logic [N_REQ*AW-1:0] req_addr = '0;
  logic [N_REQ-1:0]    gnt;
  logic                rom_rd;
  logic [AW-1:0]       rom_addr;
  logic [DW-1:0]       rom_q;
  logic                rvalid;
  logic [IDW-1:0]      rid;
  logic [DW-1:0]       rdata;
  logic                busy;

  sprite_rom_arbiter #(.N_REQ(N_REQ), .AW(AW), .DW(DW), .ROM_LAT(ROM_LAT), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .req_addr_i(req_addr), .gnt_o(gnt),
    .rom_rd_o(rom_rd), .rom_addr_o(rom_addr), .rom_q_i(rom_q), .rvalid_o(rvalid),
    .rid_o(rid), .rdata_o(rdata), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // ROM model: the word is the low byte of the address, available ROM_LAT clocks later.
  logic [DW-1:0] rom_pipe [ROM_LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_addr[7:0];
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_q = rom_pipe[ROM_LAT-1];

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  function automatic logic [N_REQ-1:0] onehot(input int i);
    logic [N_REQ-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t            sb [$];
  logic            pending [N_REQ];
  logic [AW-1:0]   addr_m  [N_REQ];
  int              wait_cnt [N_REQ];

  initial begin
    // Reset held with random traffic: everything stays quiet.
    for (int c = 0; c < 3; c++) begin
      req      = N_REQ'($urandom);
      req_addr = {$urandom, $urandom, $urandom, $urandom};
      step();
      check("rst_gnt", gnt, 0);
      check("rst_rvalid", rvalid, 0);
    end
    check("rst_rom_rd", rom_rd, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_rid", rid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_busy", busy, 0);

    // First grant after reset goes to the lowest active index.
    req = 7'b0010100;
    set_addr(2, 17'h00A55);
    rst_n = 1'b1;
    step();
    check("first_gnt", gnt, 7'b0000100);
    check("first_rom_rd", rom_rd, 1);
    check("first_rom_addr", rom_addr, 17'h00A55);
    req = '0;
    step();
    step();
    step();
    check("first_rvalid", rvalid, 1);
    check("first_rid", rid, 2);
    check("first_rdata", rdata, 8'h55);
    step();

    // Single requester latency and pulse widths.
    req = 7'b0001000;
    set_addr(3, 17'h1A2B3);
    step();
    check("single_gnt", gnt, 7'b0001000);
    check("single_rom_rd", rom_rd, 1);
    check("single_rom_addr", rom_addr, 17'h1A2B3);
    req = '0;
    step();
    check("single_gnt_pulse", gnt, 0);
    check("single_rom_rd_off", rom_rd, 0);
    check("single_busy", busy, 1);
    check("single_rvalid_early1", rvalid, 0);
    step();
    check("single_rvalid_early2", rvalid, 0);
    step();
    check("single_rvalid", rvalid, 1);
    check("single_rid", rid, 3);
    check("single_rdata", rdata, 8'hB3);
    step();
    check("single_rvalid_pulse", rvalid, 0);
    check("single_busy_idle", busy, 0);

    // Grant requester 6 so the pointer wraps to 0.
    req = 7'b1000000;
    set_addr(6, 17'h00006);
    step();
    check("wrap_prep_gnt", gnt, 7'b1000000);
    req = '0;
    for (int c = 0; c < 4; c++) step();

    // All requesters held: grants 0..6 repeating, returns continuous from the 4th clock.
    for (int i = 0; i < N_REQ; i++) set_addr(i, 17'h10000 + AW'(i * 17'h11));
    req = '1;
    for (int k = 1; k <= 17; k++) begin
      step();
      check("all_gnt", gnt, (k <= 14) ? onehot((k - 1) % N_REQ) : '0);
      if (k == 14) req = '0;
      check("all_rvalid", rvalid, (k >= 4) ? 1 : 0);
      if (k >= 4) begin
        check("all_rid", rid, (k - 4) % N_REQ);
        check("all_rdata", rdata, ((k - 4) % N_REQ) * 8'h11);
      end
    end
    step();

    // Grant 5 to place ptr at 6, then requesters 6 and 0 alternate.
    req = 7'b0100000;
    step();
    check("alt_prep_gnt", gnt, 7'b0100000);
    req = 7'b1000001;
    for (int k = 1; k <= 6; k++) begin
      step();
      check("alt_gnt", gnt, (k % 2 == 1) ? 7'b1000000 : 7'b0000001);
    end
    req = '0;
    for (int c = 0; c < 5; c++) step();

    // Reset while two reads are in flight: both are discarded.
    req = 7'b0000010;
    set_addr(1, 17'h00111);
    step();
    check("mid_gnt_a", gnt, 7'b0000010);
    req = 7'b0010000;
    set_addr(4, 17'h00144);
    step();
    check("mid_gnt_b", gnt, 7'b0010000);
    req = '0;
    step();
    check("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    step();
    check("mid_busy_rst", busy, 0);
    check("mid_gnt_rst", gnt, 0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check("mid_no_rvalid", rvalid, 0);
    end
    check("mid_busy_after", busy, 0);
    req = 7'b0000100;
    set_addr(2, 17'h0C3C3);
    step();
    check("mid_next_gnt", gnt, 7'b0000100);
    req = '0;
    step();
    step();
    step();
    check("mid_next_rvalid", rvalid, 1);
    check("mid_next_rid", rid, 2);
    check("mid_next_rdata", rdata, 8'hC3);
    step();

    // Sparse random traffic against a scoreboard; drain phase lets pending requests finish.
    for (int i = 0; i < N_REQ; i++) begin
      pending[i]  = 1'b0;
      addr_m[i]   = '0;
      wait_cnt[i] = 0;
    end
    for (int cyc = 1; cyc <= 340; cyc++) begin
      step();
      for (int i = 0; i < N_REQ; i++) if (pending[i]) wait_cnt[i]++;
      if (gnt != '0) begin
        check("rnd_gnt_onehot", $onehot(gnt), 1);
        for (int g = 0; g < N_REQ; g++) begin
          if (gnt[g]) begin
            check("rnd_gnt_pending", pending[g], 1);
            check("rnd_rom_addr", rom_addr, addr_m[g]);
            check("rnd_wait_bound", (wait_cnt[g] <= N_REQ) ? 1 : 0, 1);
            sb.push_back('{id: g, data: addr_m[g][7:0], cyc: cyc});
            pending[g] = 1'b0;
          end
        end
      end
      if (rvalid) begin
        if (sb.size() == 0) begin
          check("rnd_spurious_rvalid", rvalid, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rnd_rid", rid, e.id);
          check("rnd_rdata", rdata, e.data);
          check("rnd_latency", cyc - e.cyc, ROM_LAT + 1);
        end
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (!pending[i] && cyc < 300 && $urandom_range(0, 7) == 0) begin
          pending[i]  = 1'b1;
          addr_m[i]   = AW'($urandom);
          wait_cnt[i] = 0;
          set_addr(i, addr_m[i]);
        end
        req[i] = pending[i];
      end
    end
    check("rnd_sb_empty", sb.size(), 0);
    check("rnd_req_empty", req, 0);
    check("rnd_busy_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
